stoch_frame_ffo_count: RTL

//   Multi-word, N-channel successor of the single-cycle find-first-one/stochastic-sum stage.

---
 rtl/stoch_frame_ffo_count_if.sv | 36 +++
 rtl/stoch_frame_ffo_count.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/stoch_frame_ffo_count_if.sv
// Word-in / frame-result-out bus of the multi-channel first-one and popcount stage.
// The master drives words and takes results; the slave is the accumulator.
interface stoch_frame_ffo_count_if #(
  parameter int NCH         = 4,
  parameter int WORD_W      = 256,
  parameter int FRAME_WORDS = 4
);
  localparam int L     = WORD_W * FRAME_WORDS;
  localparam int POS_W = (L > 1) ? $clog2(L) : 1;
  localparam int CNT_W = $clog2(L + 1);
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;

  logic                    in_valid;
  logic                    in_ready;
  logic [NCH*WORD_W-1:0]   in_data;
  logic                    mode;
  logic                    out_valid;
  logic                    out_ready;
  logic [NCH-1:0]          out_found;
  logic [NCH*POS_W-1:0]    out_first_pos;
  logic [NCH*CNT_W-1:0]    out_count;
  logic [CH_W-1:0]         out_winner;
  logic                    out_winner_ok;

  modport master (
    output in_valid, in_data, mode, out_ready,
    input  in_ready, out_valid, out_found, out_first_pos, out_count,
           out_winner, out_winner_ok
  );

  modport slave (
    input  in_valid, in_data, mode, out_ready,
    output in_ready, out_valid, out_found, out_first_pos, out_count,
           out_winner, out_winner_ok
  );
endinterface

// File: rtl/stoch_frame_ffo_count.sv
// Accumulates FRAME_WORDS words per channel into earliest-'1' position and popcount,
// then presents the frame result with a registered winner channel until consumed.
//
// state | meaning
// ACCUM | accepting words, updating per-channel first-one and popcount
// DONE  | frame result presented, held until out_ready
module stoch_frame_ffo_count #(
  parameter int NCH         = 4,
  parameter int WORD_W      = 256,
  parameter int FRAME_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  stoch_frame_ffo_count_if.slave bus
);
  localparam int L     = WORD_W * FRAME_WORDS;
  localparam int POS_W = (L > 1) ? $clog2(L) : 1;
  localparam int CNT_W = $clog2(L + 1);
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int W_W   = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_e;

  state_e               state_q, state_d;
  logic                 in_ready, out_valid;
  logic                 accept, last_word, release_res;

  logic [W_W-1:0]       w_q, w_d;
  logic [NCH-1:0]       found_q, found_d;
  logic [POS_W-1:0]     pos_q [NCH];
  logic [POS_W-1:0]     pos_d [NCH];
  logic [CNT_W-1:0]     cnt_q [NCH];
  logic [CNT_W-1:0]     cnt_d [NCH];
  logic [CH_W-1:0]      winner_q, winner_d;
  logic                 winner_ok_q, winner_ok_d;

  logic [WORD_W-1:0]    word_v   [NCH];
  logic [CNT_W-1:0]     word_cnt [NCH];
  logic [IDX_W-1:0]     word_idx [NCH];
  logic [NCH-1:0]       word_any;
  logic [POS_W-1:0]     w_base;

  logic [CH_W-1:0]      win_idx;
  logic                 win_ok;
  logic [CNT_W-1:0]     best_cnt;
  logic [POS_W-1:0]     best_pos;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && last_word) state_d = DONE;
      DONE:    if (bus.out_ready)       state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // FSM: outputs; in_ready is gated by rst_n so no word is taken in a reset cycle
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM:   in_ready  = rst_n;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept      = bus.in_valid & in_ready;
  assign release_res = out_valid & bus.out_ready;
  assign last_word   = (w_q == W_W'(FRAME_WORDS - 1));
  assign w_base      = POS_W'(w_q) * POS_W'(WORD_W);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign word_v[g] = bus.in_data[g*WORD_W +: WORD_W];
    assign bus.out_first_pos[g*POS_W +: POS_W] = pos_q[g];
    assign bus.out_count[g*CNT_W +: CNT_W]     = cnt_q[g];
  end

  // Per-word popcount and lowest-set-bit; scanning downwards leaves the lowest index
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      word_cnt[c] = '0;
      word_idx[c] = '0;
      word_any[c] = |word_v[c];
      for (int i = WORD_W - 1; i >= 0; i--) begin
        word_cnt[c] = word_cnt[c] + CNT_W'(word_v[c][i]);
        if (word_v[c][i]) word_idx[c] = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_d     = w_q;
    found_d = found_q;
    for (int c = 0; c < NCH; c++) begin
      pos_d[c] = pos_q[c];
      cnt_d[c] = cnt_q[c];
    end
    if (release_res) begin
      w_d     = '0;
      found_d = '0;
      for (int c = 0; c < NCH; c++) begin
        pos_d[c] = '0;
        cnt_d[c] = '0;
      end
    end else if (accept) begin
      w_d = last_word ? '0 : w_q + 1'b1;
      for (int c = 0; c < NCH; c++) begin
        found_d[c] = found_q[c] | word_any[c];
        if (!found_q[c] && word_any[c]) pos_d[c] = w_base + POS_W'(word_idx[c]);
        cnt_d[c] = cnt_q[c] + word_cnt[c];
      end
    end
  end

  // Winner from the values that include the final word; strict compares favour low index
  always_comb begin
    win_idx  = '0;
    win_ok   = 1'b0;
    best_cnt = cnt_d[0];
    best_pos = pos_d[0];
    if (!bus.mode) begin
      for (int c = 1; c < NCH; c++) begin
        if (cnt_d[c] > best_cnt) begin
          best_cnt = cnt_d[c];
          win_idx  = CH_W'(c);
        end
      end
      win_ok = (best_cnt != '0);
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (found_d[c] && (!win_ok || pos_d[c] < best_pos)) begin
          best_pos = pos_d[c];
          win_idx  = CH_W'(c);
          win_ok   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    winner_d    = winner_q;
    winner_ok_d = winner_ok_q;
    if (release_res) begin
      winner_d    = '0;
      winner_ok_d = 1'b0;
    end else if (accept && last_word) begin
      winner_d    = win_idx;
      winner_ok_d = win_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_q         <= '0;
      found_q     <= '0;
      winner_q    <= '0;
      winner_ok_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        pos_q[c] <= '0;
        cnt_q[c] <= '0;
      end
    end else begin
      w_q         <= w_d;
      found_q     <= found_d;
      winner_q    <= winner_d;
      winner_ok_q <= winner_ok_d;
      for (int c = 0; c < NCH; c++) begin
        pos_q[c] <= pos_d[c];
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid;
  assign bus.out_found     = found_q;
  assign bus.out_winner    = winner_q;
  assign bus.out_winner_ok = winner_ok_q;
endmodule
